motor_link: RTL and testbench

MOTOR_LINK -- requirements
Module: motor_link

---
 rtl/motor_link.sv | 191 +++++++++++++++++++
 tb/tb_motor_link.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_link.sv
// motor_link -- multi-channel H-bridge driver with shared PWM and dead time.
//
// Every channel has its own command path: a pending direction/duty pair and an
// active pair that drives the bridge. All channels share one free-running PWM
// counter that counts 0 .. 2^PWM_W-2, so a channel's period is 2^PWM_W-1
// clocks. A channel changes direction directly out of COAST. Any other change
// of direction first holds both bridge inputs low for exactly DEAD_CYCLES
// clocks.
//
// Ports:
//   clk        system clock; all logic runs on the rising edge
//   rst_n      asynchronous active-low reset
//   cmd_valid  [NCH]        per-channel command strobe (one-cycle pulse)
//   cmd_dir    [2*NCH]      per-channel direction: 00 COAST, 01 FWD, 10 REV, 11 BRAKE
//   cmd_duty   [PWM_W*NCH]  per-channel duty
//   in1, in2   [NCH]        registered H-bridge inputs A/B
//   busy       [NCH]        registered: channel is in dead time
//   pwm_sync   registered one-cycle pulse that marks the first clock of each
//              output PWM period
//   dbg_state  [2*NCH]      per-channel FSM state (00 IDLE, 01 RUN, 10 DEAD)
//
// Command handshake: cmd_valid has no ready. The channel always accepts a strobe
// on the clock where it is sampled high. A later strobe overwrites the pending
// value, including during dead time.
module motor_link #(
    parameter int NCH         = 4,
    parameter int PWM_W       = 8,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       cmd_valid,
    input  logic [2*NCH-1:0]     cmd_dir,
    input  logic [PWM_W*NCH-1:0] cmd_duty,
    output logic [NCH-1:0]       in1,
    output logic [NCH-1:0]       in2,
    output logic [NCH-1:0]       busy,
    output logic                 pwm_sync,
    output logic [2*NCH-1:0]     dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    localparam logic [1:0] DIR_COAST = 2'b00;
    localparam logic [1:0] DIR_FWD   = 2'b01;
    localparam logic [1:0] DIR_REV   = 2'b10;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    localparam int              DW        = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DW-1:0]   DEAD_INIT = DW'(DEAD_CYCLES - 1);
    localparam logic [PWM_W-1:0] CNT_MAX  = PWM_W'((1 << PWM_W) - 2);

    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic             cnt_wrap;
    logic             sync_q, sync_d;
    logic [NCH-1:0]   in1_q, in1_d;
    logic [NCH-1:0]   in2_q, in2_d;
    logic [NCH-1:0]   busy_q, busy_d;
    logic [NCH-1:0]   pwm;

    logic [1:0]       state_q     [NCH];
    logic [1:0]       state_d     [NCH];
    logic [1:0]       dir_act_q   [NCH];
    logic [1:0]       dir_act_d   [NCH];
    logic [1:0]       dir_pend_q  [NCH];
    logic [1:0]       dir_pend_d  [NCH];
    logic [PWM_W-1:0] duty_act_q  [NCH];
    logic [PWM_W-1:0] duty_act_d  [NCH];
    logic [PWM_W-1:0] duty_pend_q [NCH];
    logic [PWM_W-1:0] duty_pend_d [NCH];
    logic [DW-1:0]    dead_q      [NCH];
    logic [DW-1:0]    dead_d      [NCH];

    // Shared counter. pwm_sync is registered so it lines up with the registered
    // bridge outputs. It is high on the clock whose outputs were computed from
    // cnt==0.
    always_comb begin
        cnt_wrap = (cnt_q == CNT_MAX);
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        sync_d   = (cnt_q == '0);
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i]     = state_q[i];
            dir_act_d[i]   = dir_act_q[i];
            dir_pend_d[i]  = dir_pend_q[i];
            duty_act_d[i]  = duty_act_q[i];
            duty_pend_d[i] = duty_pend_q[i];
            dead_d[i]      = dead_q[i];
            in1_d[i]       = 1'b0;
            in2_d[i]       = 1'b0;
            busy_d[i]      = (state_q[i] == ST_DEAD);
            pwm[i]         = (cnt_q < duty_act_q[i]);

            if (cmd_valid[i]) begin
                dir_pend_d[i]  = cmd_dir[2*i +: 2];
                duty_pend_d[i] = cmd_duty[PWM_W*i +: PWM_W];
            end

            case (state_q[i])
                ST_IDLE: begin
                    // Leaving COAST needs no dead time. Direction and duty
                    // take effect at once.
                    if (dir_pend_q[i] != dir_act_q[i]) begin
                        dir_act_d[i]  = dir_pend_q[i];
                        duty_act_d[i] = duty_pend_q[i];
                        state_d[i]    = (dir_pend_q[i] == DIR_COAST) ? ST_IDLE : ST_RUN;
                    end else if (cnt_wrap) begin
                        duty_act_d[i] = duty_pend_q[i];
                    end
                end
                ST_RUN: begin
                    if (dir_pend_q[i] != dir_act_q[i]) begin
                        state_d[i] = ST_DEAD;
                        dead_d[i]  = DEAD_INIT;
                    end else if (cnt_wrap) begin
                        // Update the duty on the edge where the counter returns
                        // to 0. Every output period then uses one duty value.
                        duty_act_d[i] = duty_pend_q[i];
                    end
                    case (dir_act_q[i])
                        DIR_FWD:   in1_d[i] = pwm[i];
                        DIR_REV:   in2_d[i] = pwm[i];
                        DIR_BRAKE: begin
                            in1_d[i] = 1'b1;
                            in2_d[i] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_DEAD: begin
                    // The timer never restarts. On expiry the channel takes
                    // whatever value is pending at that moment.
                    if (dead_q[i] == '0) begin
                        dir_act_d[i]  = dir_pend_q[i];
                        duty_act_d[i] = duty_pend_q[i];
                        state_d[i]    = (dir_pend_q[i] == DIR_COAST) ? ST_IDLE : ST_RUN;
                    end else begin
                        dead_d[i] = dead_q[i] - 1'b1;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sync_q <= 1'b0;
            in1_q  <= '0;
            in2_q  <= '0;
            busy_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i]     <= ST_IDLE;
                dir_act_q[i]   <= DIR_COAST;
                dir_pend_q[i]  <= DIR_COAST;
                duty_act_q[i]  <= '0;
                duty_pend_q[i] <= '0;
                dead_q[i]      <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
            in1_q  <= in1_d;
            in2_q  <= in2_d;
            busy_q <= busy_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i]     <= state_d[i];
                dir_act_q[i]   <= dir_act_d[i];
                dir_pend_q[i]  <= dir_pend_d[i];
                duty_act_q[i]  <= duty_act_d[i];
                duty_pend_q[i] <= duty_pend_d[i];
                dead_q[i]      <= dead_d[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_dbg
        assign dbg_state[2*g +: 2] = state_q[g];
    end

    assign in1      = in1_q;
    assign in2      = in2_q;
    assign busy     = busy_q;
    assign pwm_sync = sync_q;

endmodule

// File: tb/tb_motor_link.sv
// Directed testbench for motor_link (NCH=4, PWM_W=8, DEAD_CYCLES=16).
// The bench drives inputs on the falling clock edge and samples outputs there too.
module tb_motor_link;

    localparam logic [1:0] COAST = 2'b00;
    localparam logic [1:0] FWD   = 2'b01;
    localparam logic [1:0] REV   = 2'b10;
    localparam logic [1:0] BRAKE = 2'b11;

    logic        clk;
    logic        rst_n;
    logic [3:0]  cmd_valid;
    logic [7:0]  cmd_dir;
    logic [31:0] cmd_duty;
    logic [3:0]  in1;
    logic [3:0]  in2;
    logic [3:0]  busy;
    logic        pwm_sync;
    logic [7:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    motor_link #(.NCH(4), .PWM_W(8), .DEAD_CYCLES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .cmd_duty  (cmd_duty),
        .in1       (in1),
        .in2       (in2),
        .busy      (busy),
        .pwm_sync  (pwm_sync),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- drivers ----------------
    task automatic drive_cmd(input logic [3:0] m, input logic [7:0] d, input logic [31:0] u);
        @(negedge clk);
        cmd_valid = m;
        cmd_dir   = d;
        cmd_duty  = u;
        @(negedge clk);
        cmd_valid = '0;
    endtask

    task automatic send_ch(input int ch, input logic [1:0] dir, input logic [7:0] duty);
        logic [3:0]  m;
        logic [7:0]  d;
        logic [31:0] u;
        m = '0;
        d = '0;
        u = '0;
        m[ch]          = 1'b1;
        d[2*ch +: 2]   = dir;
        u[8*ch +: 8]   = duty;
        drive_cmd(m, d, u);
    endtask

    task automatic wait_sync(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (pwm_sync) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Samples one full 255-clock period, starting with the current sample.
    task automatic measure(input int ch, output int hi1, output int hi2,
                           output int run1, output int nbusy);
        bit lead;
        hi1 = 0; hi2 = 0; run1 = 0; nbusy = 0; lead = 1'b1;
        for (int k = 0; k < 255; k++) begin
            if (k > 0) @(negedge clk);
            if (in1[ch]) hi1++;
            if (in1[ch] && lead) run1++;
            else lead = 1'b0;
            if (in2[ch]) hi2++;
            if (busy[ch]) nbusy++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int gap;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in1 !== 4'h0) begin errors++; $display("FAIL reset_in1: got %h want 0", in1); end
        checks++; if (in2 !== 4'h0) begin errors++; $display("FAIL reset_in2: got %h want 0", in2); end
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy); end
        checks++; if (pwm_sync !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b want 0", pwm_sync); end
        checks++; if (dbg_state !== 8'h00) begin errors++; $display("FAIL reset_state: got %h want 00", dbg_state); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (pwm_sync !== 1'b1) begin errors++; $display("FAIL first_sync: got %b want 1", pwm_sync); end
        gap = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            gap++;
            if (pwm_sync) break;
        end
        checks++; if (gap != 255) begin errors++; $display("FAIL sync_period: got %0d want 255", gap); end
    endtask

    task automatic test_fwd_duty;
        bit ok;
        int h1, h2, r1, nb;
        send_ch(0, FWD, 8'd64);
        repeat (3) @(negedge clk);
        wait_sync(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fwd64_sync_timeout: got 0 want 1"); end
        measure(0, h1, h2, r1, nb);
        checks++; if (h1 != 64) begin errors++; $display("FAIL fwd64_high: got %0d want 64", h1); end
        checks++; if (r1 != 64) begin errors++; $display("FAIL fwd64_lead_run: got %0d want 64", r1); end
        checks++; if (h2 != 0) begin errors++; $display("FAIL fwd64_in2: got %0d want 0", h2); end
        checks++; if (nb != 0) begin errors++; $display("FAIL fwd64_busy: got %0d want 0", nb); end
    endtask

    task automatic test_reverse_dead;
        bit ok;
        int h1, h2, r1, nb, len, viol;
        send_ch(0, FWD, 8'd128);
        repeat (3) @(negedge clk);
        wait_sync(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fwd128_sync_timeout: got 0 want 1"); end
        measure(0, h1, h2, r1, nb);
        checks++; if (h1 != 128) begin errors++; $display("FAIL fwd128_high: got %0d want 128", h1); end
        checks++; if (nb != 0) begin errors++; $display("FAIL fwd128_busy: got %0d want 0", nb); end

        send_ch(0, REV, 8'd128);
        @(negedge clk);
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rev_busy_t1: got %b want 0", busy[0]); end
        len = 0; viol = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy[0]) break;
            len++;
            if (in1[0] || in2[0]) viol++;
        end
        checks++; if (len != 16) begin errors++; $display("FAIL rev_dead_len: got %0d want 16", len); end
        checks++; if (viol != 0) begin errors++; $display("FAIL rev_dead_outputs: got %0d active want 0", viol); end
        checks++; if (in1[0] !== 1'b0) begin errors++; $display("FAIL rev_after_in1: got %b want 0", in1[0]); end

        repeat (3) @(negedge clk);
        wait_sync(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rev128_sync_timeout: got 0 want 1"); end
        measure(0, h1, h2, r1, nb);
        checks++; if (h2 != 128) begin errors++; $display("FAIL rev128_in2_high: got %0d want 128", h2); end
        checks++; if (h1 != 0) begin errors++; $display("FAIL rev128_in1: got %0d want 0", h1); end
        checks++; if (nb != 0) begin errors++; $display("FAIL rev128_busy: got %0d want 0", nb); end
    endtask

    task automatic test_duty_update;
        bit ok;
        int h1, h2, r1, nb, hi_first, busy_first;
        send_ch(1, FWD, 8'd10);
        repeat (3) @(negedge clk);
        wait_sync(ok);
        checks++; if (!ok) begin errors++; $display("FAIL duty10_sync_timeout: got 0 want 1"); end
        hi_first = 0; busy_first = 0;
        for (int k = 0; k < 255; k++) begin
            if (k > 0) @(negedge clk);
            if (in1[1]) hi_first++;
            if (busy[1]) busy_first++;
            if (k == 50) begin
                cmd_valid = 4'b0010;
                cmd_dir   = 8'b0000_0100;
                cmd_duty  = {8'd0, 8'd0, 8'd200, 8'd0};
            end
            if (k == 51) cmd_valid = '0;
        end
        checks++; if (hi_first != 10) begin errors++; $display("FAIL duty_cur_period: got %0d want 10", hi_first); end
        @(negedge clk);
        checks++; if (pwm_sync !== 1'b1) begin errors++; $display("FAIL duty_next_sync: got %b want 1", pwm_sync); end
        measure(1, h1, h2, r1, nb);
        checks++; if (h1 != 200) begin errors++; $display("FAIL duty_next_period: got %0d want 200", h1); end
        checks++; if (r1 != 200) begin errors++; $display("FAIL duty_next_run: got %0d want 200", r1); end
        checks++; if (nb + busy_first != 0) begin errors++; $display("FAIL duty_busy: got %0d want 0", nb + busy_first); end
    endtask

    task automatic test_dead_override;
        int len, viol;
        send_ch(2, FWD, 8'd100);
        repeat (3) @(negedge clk);
        send_ch(2, REV, 8'd100);
        @(negedge clk);
        checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL ovr_busy_t1: got %b want 0", busy[2]); end
        len = 0; viol = 0;
        for (int k = 2; k < 42; k++) begin
            @(negedge clk);
            if (!busy[2]) break;
            len++;
            if (in1[2] || in2[2]) viol++;
            if (k == 5) begin
                cmd_valid = 4'b0100;
                cmd_dir   = 8'b0011_0000;
                cmd_duty  = '0;
            end
            if (k == 6) cmd_valid = '0;
        end
        checks++; if (len != 16) begin errors++; $display("FAIL ovr_dead_len: got %0d want 16", len); end
        checks++; if (viol != 0) begin errors++; $display("FAIL ovr_dead_outputs: got %0d active want 0", viol); end
        checks++; if ({in1[2], in2[2]} !== 2'b11) begin errors++; $display("FAIL ovr_brake: got %b want 11", {in1[2], in2[2]}); end
        repeat (5) @(negedge clk);
        checks++; if ({in1[2], in2[2], busy[2]} !== 3'b110) begin errors++; $display("FAIL ovr_brake_hold: got %b want 110", {in1[2], in2[2], busy[2]}); end
    endtask

    task automatic test_simultaneous;
        drive_cmd(4'b0111, 8'h00, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 4'b0111) begin errors++; $display("FAIL coast_all_busy: got %b want 0111", busy); end
        repeat (25) @(negedge clk);
        checks++; if ({in1, in2, busy} !== 12'h000) begin errors++; $display("FAIL coast_all_idle: got %h want 000", {in1, in2, busy}); end
        checks++; if (dbg_state !== 8'h00) begin errors++; $display("FAIL coast_all_state: got %h want 00", dbg_state); end

        drive_cmd(4'b1111, 8'b00_11_10_01, {8'd50, 8'd0, 8'd255, 8'd255});
        @(negedge clk);
        checks++; if ({in1, in2} !== 8'h00) begin errors++; $display("FAIL simul_t1: got %h want 00", {in1, in2}); end
        @(negedge clk);
        checks++; if (in1 !== 4'b0101) begin errors++; $display("FAIL simul_in1: got %b want 0101", in1); end
        checks++; if (in2 !== 4'b0110) begin errors++; $display("FAIL simul_in2: got %b want 0110", in2); end
        checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL simul_busy: got %b want 0000", busy); end
        checks++; if (dbg_state !== 8'h15) begin errors++; $display("FAIL simul_state: got %h want 15", dbg_state); end
        repeat (4) @(negedge clk);
        checks++; if ({in1, in2, busy} !== 12'h560) begin errors++; $display("FAIL simul_hold: got %h want 560", {in1, in2, busy}); end
    endtask

    task automatic test_reset_mid_dead;
        send_ch(3, FWD, 8'd255);
        repeat (3) @(negedge clk);
        checks++; if ({in1, in2} !== 8'hD6) begin errors++; $display("FAIL ch3_fwd: got %h want d6", {in1, in2}); end
        send_ch(3, REV, 8'd255);
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 4'b1000) begin errors++; $display("FAIL ch3_dead: got %b want 1000", busy); end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({in1, in2, busy} !== 12'h000) begin errors++; $display("FAIL async_rst_out: got %h want 000", {in1, in2, busy}); end
        checks++; if (pwm_sync !== 1'b0) begin errors++; $display("FAIL async_rst_sync: got %b want 0", pwm_sync); end
        checks++; if (dbg_state !== 8'h00) begin errors++; $display("FAIL async_rst_state: got %h want 00", dbg_state); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (pwm_sync !== 1'b1) begin errors++; $display("FAIL rel_sync: got %b want 1", pwm_sync); end
        @(negedge clk);
        checks++; if (pwm_sync !== 1'b0) begin errors++; $display("FAIL rel_sync_pulse: got %b want 0", pwm_sync); end
        repeat (30) @(negedge clk);
        checks++; if ({in1, in2, busy} !== 12'h000) begin errors++; $display("FAIL rel_quiet: got %h want 000", {in1, in2, busy}); end
        checks++; if (dbg_state !== 8'h00) begin errors++; $display("FAIL rel_state: got %h want 00", dbg_state); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        cmd_valid = '0;
        cmd_dir   = '0;
        cmd_duty  = '0;
        test_reset();
        test_fwd_duty();
        test_reverse_dead();
        test_duty_update();
        test_dead_override();
        test_simultaneous();
        test_reset_mid_dead();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
